// File: rtl/inst_text_writer_pkg.sv
// Shared debug-display definitions: writer FSM states, glyph constants and the
// default text-screen geometry used by the VGA text controller.
package inst_text_writer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StFin
  } state_e;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_QMARK = 8'h3F;

  localparam int unsigned DEFAULT_COLS = 80;
  localparam int unsigned DEFAULT_ROWS = 30;

endpackage

// File: rtl/char_sanitize.sv
// Maps any byte onto something the glyph ROM can draw: NUL becomes a space,
// other non-printables become '?'.
module char_sanitize
  import inst_text_writer_pkg::*;
(
  input  logic [7:0] raw,
  output logic [7:0] clean
);

  always_comb begin
    clean = raw;
    if (raw == 8'h00) begin
      clean = CHAR_SPACE;
    end else if (raw < 8'h20 || raw > 8'h7E) begin
      clean = CHAR_QMARK;
    end
  end

endmodule

// File: rtl/inst_text_writer.sv
// Writes one fixed-width instruction string into the debug character RAM,
// one character per cycle, clipping at the right screen edge.
module inst_text_writer
  import inst_text_writer_pkg::*;
#(
  parameter int unsigned CHARS  = 19,
  parameter int unsigned COLS   = DEFAULT_COLS,
  parameter int unsigned ROWS   = DEFAULT_ROWS,
  parameter int unsigned ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_row,
  input  logic [6:0]          req_col,
  input  logic [CHARS*8-1:0]  req_str,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [7:0]          wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IDX_W  = $clog2(CHARS);
  localparam int unsigned BASE_W = ADDR_W + 1;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHARS*8-1:0] str_q;
  logic [BASE_W-1:0]  base_q;
  logic [6:0]         col_l_q;

  logic [IDX_W-1:0]   sel_idx;
  logic [CHARS*8-1:0] sel_str;
  logic [6:0]         sel_col;
  logic [7:0]         col_sum;
  logic [BASE_W-1:0]  accept_base;
  logic [7:0]         raw_byte;
  logic [7:0]         clean_byte;
  logic               last_char;
  logic               advance;

  // Outputs are registered, so everything here describes the character that
  // will be presented in the cycle after the coming edge.
  always_comb begin
    last_char   = (idx_q == IDX_W'(CHARS - 1));
    advance     = wr_ready || !wr_en;
    accept_base = BASE_W'(req_row) * BASE_W'(COLS) + BASE_W'(req_col);
    if (state_q == StIdle) begin
      sel_str = req_str;
      sel_idx = '0;
      sel_col = req_col;
    end else begin
      sel_str = str_q;
      sel_idx = last_char ? '0 : idx_q + IDX_W'(1);
      sel_col = col_l_q;
    end
    col_sum  = {1'b0, sel_col} + 8'(sel_idx);
    raw_byte = 8'(sel_str >> ((CHARS - 1 - 32'(sel_idx)) * 8));
  end

  char_sanitize u_char_sanitize (
    .raw   (raw_byte),
    .clean (clean_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      str_q     <= '0;
      base_q    <= '0;
      col_l_q   <= '0;
      req_ready <= 1'b1;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= CHAR_SPACE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            str_q     <= req_str;
            base_q    <= accept_base;
            idx_q     <= '0;
            col_l_q   <= req_col;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            if (32'(req_row) >= ROWS) begin
              state_q <= StFin;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_q <= StWrite;
              wr_en   <= 32'(col_sum) < COLS;
              wr_addr <= ADDR_W'(accept_base);
              wr_data <= clean_byte;
            end
          end
        end
        StWrite: begin
          // Clipped characters (wr_en low) advance without waiting on the RAM.
          if (advance) begin
            if (last_char) begin
              state_q <= StFin;
              wr_en   <= 1'b0;
              done    <= 1'b1;
            end else begin
              idx_q   <= sel_idx;
              wr_en   <= 32'(col_sum) < COLS;
              wr_addr <= ADDR_W'(base_q + BASE_W'(sel_idx));
              wr_data <= clean_byte;
            end
          end
        end
        StFin: begin
          state_q   <= StIdle;
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
